// File: rtl/bch_31_pkg.sv
// -----------------------------------------------------------------------------
// bch_31_pkg
// Shared definitions for the BCH(31,21) t=2 encoder and pipelined decoder.
//   N, K, M        : code length, message length, field degree
//   GEN_POLY       : g(x) = m1(x)*m3(x) = x^10+x^9+x^8+x^6+x^5+x^3+1
//   PRIM_POLY      : p(x) = x^5+x^2+1, defines GF(32), alpha = 5'b00010
//   ALPHA_POW      : antilog table, ALPHA_POW[i] = alpha^i, i = 0..30
//   ALPHA_LOG      : log table, ALPHA_LOG[alpha^i] = i (entry 0 unused)
//   gf_mul/gf_pow/gf_inv/alpha_pow : GF(32) arithmetic helpers
//   err_class_t    : decoder verdict carried down the pipeline
// -----------------------------------------------------------------------------
package bch_31_pkg;

   localparam int N = 31;
   localparam int K = 21;
   localparam int M = 5;

   localparam logic [10:0] GEN_POLY  = 11'b111_0110_1001;
   localparam logic [5:0]  PRIM_POLY = 6'b10_0101;

   typedef logic [M-1:0] gf_t;

   typedef enum logic [1:0] {
      CLS_NONE   = 2'd0,
      CLS_SINGLE = 2'd1,
      CLS_DOUBLE = 2'd2,
      CLS_UNCORR = 2'd3
   } err_class_t;

   localparam gf_t ALPHA_POW [0:30] = '{
      5'd1,  5'd2,  5'd4,  5'd8,  5'd16, 5'd5,  5'd10, 5'd20,
      5'd13, 5'd26, 5'd17, 5'd7,  5'd14, 5'd28, 5'd29, 5'd31,
      5'd27, 5'd19, 5'd3,  5'd6,  5'd12, 5'd24, 5'd21, 5'd15,
      5'd30, 5'd25, 5'd23, 5'd11, 5'd22, 5'd9,  5'd18
   };

   localparam logic [4:0] ALPHA_LOG [0:31] = '{
      5'd0,  5'd0,  5'd1,  5'd18, 5'd2,  5'd5,  5'd19, 5'd11,
      5'd3,  5'd29, 5'd6,  5'd27, 5'd20, 5'd8,  5'd12, 5'd23,
      5'd4,  5'd10, 5'd30, 5'd17, 5'd7,  5'd22, 5'd28, 5'd26,
      5'd21, 5'd25, 5'd9,  5'd16, 5'd13, 5'd14, 5'd24, 5'd15
   };

   // alpha^e for any non-negative exponent; the order of alpha is 31.
   function automatic gf_t alpha_pow(input int e);
      return ALPHA_POW[5'(e % 31)];
   endfunction

   // Carry-less product followed by reduction modulo p(x).
   function automatic gf_t gf_mul(input gf_t a, input gf_t b);
      logic [9:0] p;
      p = '0;
      for (int i = 0; i < M; i++) begin
         if (b[i]) p = p ^ ({5'b0, a} << i);
      end
      for (int i = 8; i >= M; i--) begin
         if (p[i]) p = p ^ ({4'b0, PRIM_POLY} << (i - M));
      end
      return p[4:0];
   endfunction

   // Square-and-multiply over a 5-bit exponent.
   function automatic gf_t gf_pow(input gf_t a, input logic [4:0] e);
      gf_t r;
      r = 5'd1;
      for (int i = 4; i >= 0; i--) begin
         r = gf_mul(r, r);
         if (e[i]) r = gf_mul(r, a);
      end
      return r;
   endfunction

   // Inverse via log tables: alpha^-l = alpha^(31-l). Zero maps to zero.
   function automatic gf_t gf_inv(input gf_t a);
      logic [4:0] l;
      l = ALPHA_LOG[a];
      if (a == '0)      return '0;
      else if (l == '0) return 5'd1;
      else              return ALPHA_POW[5'd31 - l];
   endfunction

endpackage

// File: rtl/bch_31_chien.sv
// -----------------------------------------------------------------------------
// bch_31_chien
// Combinational parallel Chien search and correction for all 31 positions.
//   sigma1, sigma2 in  : locator coefficients, sigma(x)=1+sigma1*x+sigma2*x^2
//   cls_in         in  : class decided from the syndromes
//   rx      [30:0] in  : received word
//   corrected [30:0] out : rx with located bits flipped, or rx unchanged
//   uncorrectable    out : final verdict, includes root-count disagreement
// -----------------------------------------------------------------------------
module bch_31_chien
   import bch_31_pkg::*;
(
   input  gf_t          sigma1,
   input  gf_t          sigma2,
   input  err_class_t   cls_in,
   input  logic [N-1:0] rx,
   output logic [N-1:0] corrected,
   output logic         uncorrectable
);

   logic [N-1:0] roots;
   logic [5:0]   root_cnt;
   logic         fix_ok;

   always_comb begin
      roots = '0;
      // sigma(alpha^-i) = 0  <=>  sigma1*alpha^-i + sigma2*alpha^-2i = 1
      for (int i = 0; i < N; i++) begin
         roots[i] = (gf_mul(sigma1, alpha_pow(31 - i)) ^
                     gf_mul(sigma2, alpha_pow(62 - 2*i))) == 5'd1;
      end
      root_cnt = 6'($countones(roots));
      // Only trust the roots when their count matches the locator degree.
      fix_ok = ((cls_in == CLS_SINGLE) && (root_cnt == 6'd1)) ||
               ((cls_in == CLS_DOUBLE) && (root_cnt == 6'd2));
      corrected     = fix_ok ? (rx ^ roots) : rx;
      uncorrectable = (cls_in != CLS_NONE) && !fix_ok;
   end

endmodule

// File: rtl/bch_31_encoder.sv
// -----------------------------------------------------------------------------
// bch_31_encoder
// Combinational systematic BCH(31,21) encoder.
//   msg      [20:0] in  : message, becomes codeword[30:10]
//   codeword [30:0] out : {msg, msg(x)*x^10 mod g(x)}
// -----------------------------------------------------------------------------
module bch_31_encoder
   import bch_31_pkg::*;
(
   input  logic [K-1:0] msg,
   output logic [N-1:0] codeword
);

   logic [N-K-1:0] rem;
   logic           fb;

   // Division LFSR unrolled over the message bits, most significant first.
   always_comb begin
      rem = '0;
      fb  = 1'b0;
      for (int i = K-1; i >= 0; i--) begin
         fb  = msg[i] ^ rem[N-K-1];
         rem = {rem[N-K-2:0], 1'b0};
         if (fb) rem = rem ^ GEN_POLY[N-K-1:0];
      end
      codeword = {msg, rem};
   end

endmodule

// File: rtl/bch_31_pipe.sv
// -----------------------------------------------------------------------------
// bch_31_pipe
// Three-stage BCH(31,21) t=2 decoder: syndromes, locator/class, Chien search.
//   clk                         : single clock, rising edge
//   rst                         : asynchronous, active-low reset
//   codeword             [30:0] : received word, bit i = coefficient of x^i
//   corrected_codeword_o [30:0] : registered corrected word
//   error_detected              : nonzero syndrome, aligned with the word
//   uncorrectable_o             : only with BCH_31_UNCORRECTABLE_EN defined;
//                                 high when the word could not be corrected
// Flow control: none. A word is taken every clock and its result leaves
// exactly three rising edges later; there is no valid/ready handshake.
// -----------------------------------------------------------------------------
module bch_31_pipe
   import bch_31_pkg::*;
(
   input  logic         clk,
   input  logic         rst,
   input  logic [N-1:0] codeword,
   output logic [N-1:0] corrected_codeword_o,
   output logic         error_detected
`ifdef BCH_31_UNCORRECTABLE_EN
   ,
   output logic         uncorrectable_o
`endif
);

   // ---------------- stage 1: syndromes ----------------
   gf_t          s1_c, s3_c;
   gf_t          s1_q, s3_q;
   logic [N-1:0] rx1_q;

   always_comb begin
      s1_c = '0;
      s3_c = '0;
      for (int i = 0; i < N; i++) begin
         if (codeword[i]) begin
            s1_c = s1_c ^ alpha_pow(i);
            s3_c = s3_c ^ alpha_pow(3*i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q  <= '0;
         s3_q  <= '0;
         rx1_q <= '0;
      end else begin
         s1_q  <= s1_c;
         s3_q  <= s3_c;
         rx1_q <= codeword;
      end
   end

   // ---------------- stage 2: locator and class ----------------
   gf_t          s1_cube;
   gf_t          sig1_c, sig2_c;
   err_class_t   cls_c;
   gf_t          sig1_q, sig2_q;
   err_class_t   cls_q;
   logic [N-1:0] rx2_q;

   always_comb begin
      s1_cube = gf_pow(s1_q, 5'd3);
      sig1_c  = '0;
      sig2_c  = '0;
      cls_c   = CLS_NONE;
      if (s1_q == '0) begin
         cls_c = (s3_q == '0) ? CLS_NONE : CLS_UNCORR;
      end else if (s3_q == s1_cube) begin
         cls_c  = CLS_SINGLE;
         sig1_c = s1_q;
      end else begin
         cls_c  = CLS_DOUBLE;
         sig1_c = s1_q;
         sig2_c = gf_mul(s3_q ^ s1_cube, gf_inv(s1_q));
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sig1_q <= '0;
         sig2_q <= '0;
         cls_q  <= CLS_NONE;
         rx2_q  <= '0;
      end else begin
         sig1_q <= sig1_c;
         sig2_q <= sig2_c;
         cls_q  <= cls_c;
         rx2_q  <= rx1_q;
      end
   end

   // ---------------- stage 3: Chien search and output ----------------
   logic [N-1:0] corr_c;
   logic         unc_c;
   logic         err_c;

   bch_31_chien u_chien (
      .sigma1        (sig1_q),
      .sigma2        (sig2_q),
      .cls_in        (cls_q),
      .rx            (rx2_q),
      .corrected     (corr_c),
      .uncorrectable (unc_c)
   );

   // An uncorrectable verdict is only ever reached from a nonzero syndrome,
   // so folding it in leaves the flag equal to "syndromes nonzero".
   assign err_c = (cls_q != CLS_NONE) || unc_c;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         corrected_codeword_o <= '0;
         error_detected       <= 1'b0;
      end else begin
         corrected_codeword_o <= corr_c;
         error_detected       <= err_c;
      end
   end

`ifdef BCH_31_UNCORRECTABLE_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) uncorrectable_o <= 1'b0;
      else      uncorrectable_o <= unc_c;
   end
`endif

endmodule

// File: tb/tb_bch_31_pipe.sv
// -----------------------------------------------------------------------------
// tb_bch_31_pipe
// Bench for bch_31_pipe and bch_31_encoder. Words are driven on the falling
// edge, expected results are queued at drive time and popped when a bench-side
// three-stage valid delay line says the matching result is on the outputs.
// Define BCH_31_UNCORRECTABLE_EN for both bench and RTL to cover that port.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_bch_31_pipe;

   localparam logic [10:0] G = 11'b111_0110_1001;

   // ---------------- clock / reset ----------------
   logic        clk;
   logic        rst;
   logic [30:0] codeword;
   logic [30:0] corrected_codeword_o;
   logic        error_detected;
`ifdef BCH_31_UNCORRECTABLE_EN
   logic        uncorrectable_o;
`endif
   logic [20:0] msg;
   logic [30:0] enc_cw;
   logic        drv_valid;
   logic [2:0]  vpipe;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   bch_31_pipe dut (
      .clk                  (clk),
      .rst                  (rst),
      .codeword             (codeword),
      .corrected_codeword_o (corrected_codeword_o),
      .error_detected       (error_detected)
`ifdef BCH_31_UNCORRECTABLE_EN
      ,
      .uncorrectable_o      (uncorrectable_o)
`endif
   );

   bch_31_encoder enc (
      .msg      (msg),
      .codeword (enc_cw)
   );

   // ---------------- reference model ----------------
   function automatic logic [30:0] enc_model(input logic [20:0] m);
      logic [30:0] v;
      v = {m, 10'b0};
      for (int b = 30; b >= 10; b--)
         if (v[b]) v = v ^ (31'(G) << (b - 10));
      return {m, v[9:0]};
   endfunction

   function automatic logic is_codeword(input logic [30:0] c);
      logic [30:0] v;
      v = c;
      for (int b = 30; b >= 10; b--)
         if (v[b]) v = v ^ (31'(G) << (b - 10));
      return v[9:0] == 10'd0;
   endfunction

   function automatic logic [30:0] rand_err(input int nerr);
      logic [30:0] m;
      m = '0;
      while ($countones(m) < nerr) m[$urandom_range(30, 0)] = 1'b1;
      return m;
   endfunction

   // ---------------- scoreboard ----------------
   typedef struct packed {
      logic [30:0] rx;
      logic [30:0] word;
      logic        err;
      logic        three;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(posedge clk or negedge rst) begin
      if (!rst) vpipe <= '0;
      else      vpipe <= {vpipe[1:0], drv_valid};
   end

   exp_t mon_e;
   logic mon_ok;
   always @(negedge clk) begin
      if (vpipe[2]) begin
         if (exp_q.size() == 0) begin
            check("sb_underflow", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            if (!mon_e.three) begin
               check("word", {1'b0, corrected_codeword_o}, {1'b0, mon_e.word});
               check("err",  32'(error_detected), 32'(mon_e.err));
`ifdef BCH_31_UNCORRECTABLE_EN
               check("unc",  32'(uncorrectable_o), 32'd0);
`endif
            end else begin
               mon_ok = (corrected_codeword_o == mon_e.rx) || is_codeword(corrected_codeword_o);
               check("err3",  32'(error_detected), 32'd1);
               check("corr3", 32'(mon_ok), 32'd1);
`ifdef BCH_31_UNCORRECTABLE_EN
               check("unc3", 32'(uncorrectable_o), 32'(corrected_codeword_o == mon_e.rx));
`endif
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send(input logic [30:0] cw, input logic [30:0] emask, input logic three);
      exp_t e;
      @(negedge clk);
      codeword  = cw ^ emask;
      drv_valid = 1'b1;
      e.rx    = cw ^ emask;
      e.word  = cw;
      e.err   = (emask != '0);
      e.three = three;
      exp_q.push_back(e);
   endtask

   task automatic drain();
      int n;
      @(negedge clk);
      drv_valid = 1'b0;
      n = 0;
      while (exp_q.size() != 0 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("drain_left", 32'(exp_q.size()), 32'd0);
   endtask

   task automatic check_outputs_zero(input string tag);
      check(tag, {1'b0, corrected_codeword_o}, 32'd0);
      check(tag, 32'(error_detected), 32'd0);
`ifdef BCH_31_UNCORRECTABLE_EN
      check(tag, 32'(uncorrectable_o), 32'd0);
`endif
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [30:0] cw;
      rst       = 1'b1;
      codeword  = '0;
      drv_valid = 1'b0;
      msg       = '0;
      #2 rst = 1'b0;
      #1 check_outputs_zero("reset_async");
      repeat (2) @(negedge clk);
      check_outputs_zero("reset_hold");

      // encoder
      msg = 21'h0;       #1 check("enc_zero", {1'b0, enc_cw}, 32'd0);
      msg = 21'h1;       #1 check("enc_msg1", {1'b0, enc_cw}, 32'h0000_0769);
      for (int i = 0; i < 8; i++) begin
         msg = 21'($urandom_range(21'h1F_FFFF, 0));
         #1 check("enc_rand", {1'b0, enc_cw}, {1'b0, enc_model(msg)});
      end

      @(negedge clk);
      rst = 1'b1;

      // clean words
      send(31'h0, 31'h0, 1'b0);
      send(enc_model(21'h1), 31'h0, 1'b0);
      // every single-bit error, back-to-back
      for (int i = 0; i < 31; i++) send(31'h0, 31'h1 << i, 1'b0);
      // every two-bit error pair
      for (int i = 0; i < 31; i++)
         for (int j = i + 1; j < 31; j++)
            send(31'h0, (31'h1 << i) | (31'h1 << j), 1'b0);
      // three errors: outcome must be the input or some valid codeword
      send(31'h0, 31'h7, 1'b1);
      // random messages with 0..2 random errors
      for (int k = 0; k < 200; k++) begin
         cw = enc_model(21'($urandom_range(21'h1F_FFFF, 0)));
         send(cw, rand_err($urandom_range(2, 0)), 1'b0);
      end
      for (int k = 0; k < 10; k++) begin
         cw = enc_model(21'($urandom_range(21'h1F_FFFF, 0)));
         send(cw, rand_err(3), 1'b1);
      end
      drain();

      // reset mid-stream with errored words in flight
      for (int k = 0; k < 5; k++) send(31'h0, 31'h3 << k, 1'b0);
      @(posedge clk);
      #2 rst = 1'b0;
      drv_valid = 1'b0;
      codeword  = '0;
      exp_q.delete();
      #1 check_outputs_zero("mid_reset");
      @(negedge clk);
      check_outputs_zero("mid_reset_hold");
      rst = 1'b1;
      // first result three edges after the first sampled word
      send(enc_model(21'h1), 31'h1 << 17, 1'b0);
      @(negedge clk);
      drv_valid = 1'b0;
      check_outputs_zero("lat_edge1");
      @(negedge clk);
      check_outputs_zero("lat_edge2");
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: timeout reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
